// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Holds the FSM state encoding and the length-header legality check.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LOAD   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  // The full 16-bit word count is compared, so values above DEPTH are never aliased
  function automatic logic len_ok(input logic [15:0] len, input int unsigned depth);
    return (len != 16'd0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
// The master drives bytes and the slave returns ready.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: shifts bytes in from the top so byte 0 lands in bits 7:0,
// and flags the cycle in which the fourth byte of a word arrives.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_word_valid,
  output logic [WIDTH-1:0] o_word
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int HELD_W = WIDTH - BYTE_W;

  logic [LANE_W-1:0] r_lane;
  logic [HELD_W-1:0] r_held;

  // Lane counter and the three bytes held ahead of the completing byte
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lane <= '0;
      r_held <= '0;
    end else if (i_byte_valid) begin
      r_lane <= r_lane + LANE_W'(1);
      r_held <= {i_byte, r_held[HELD_W-1:BYTE_W]};
    end else begin
      r_lane <= r_lane;
      r_held <= r_held;
    end
  end

  assign o_word_valid = i_byte_valid && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_held};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes packed words into
// instruction memory and holds the core in reset until the program is committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  imem_loader_if.slave      s_in,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [7:0]        r_len_lo;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic              r_core_reset;
  logic              r_done;
  logic              r_error;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_hdr_len;
  logic              w_hdr_ok;
  logic              w_pack_valid;
  logic              w_word_valid;
  logic [WIDTH-1:0]  w_word;
  logic              w_last_word;

  assign w_accept     = s_in.in_valid && w_ready;
  assign w_hdr_len    = {s_in.in_data, r_len_lo};
  assign w_hdr_ok     = len_ok(w_hdr_len, DEPTH);
  assign w_pack_valid = w_accept && (r_state == ST_LOAD);
  assign w_last_word  = ((r_word_cnt + CNT_W'(1)) == r_len);

  byte_packer #(.WIDTH(WIDTH)) u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_byte_valid (w_pack_valid),
    .i_byte       (s_in.in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Ready only while still consuming the stream, and never during reset
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_LOAD: w_ready = 1'b1;
      default:                       w_ready = 1'b0;
    endcase
    if (i_reset) begin
      w_ready = 1'b0;
    end else begin
      w_ready = w_ready;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN_LO: begin
        if (w_accept) w_next = ST_LEN_HI;
        else          w_next = r_state;
      end
      ST_LEN_HI: begin
        if (w_accept) w_next = w_hdr_ok ? ST_LOAD : ST_ERROR;
        else          w_next = r_state;
      end
      ST_LOAD: begin
        if (w_word_valid && w_last_word) w_next = ST_COMMIT;
        else                             w_next = r_state;
      end
      ST_COMMIT: w_next = ST_DONE;
      ST_DONE:   w_next = ST_DONE;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_LEN_LO;
    endcase
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_LEN_LO;
    else         r_state <= w_next;
  end

  // Header capture, word counter, write port and status outputs (status follows next state)
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_len_lo     <= 8'd0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if ((r_state == ST_LEN_LO) && w_accept) r_len_lo <= s_in.in_data;
      else                                    r_len_lo <= r_len_lo;

      if ((r_state == ST_LEN_HI) && w_accept) begin
        r_len      <= w_hdr_len[CNT_W-1:0];
        r_word_cnt <= '0;
      end else if (w_word_valid) begin
        r_len      <= r_len;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end else begin
        r_len      <= r_len;
        r_word_cnt <= r_word_cnt;
      end

      r_mem_we <= w_word_valid;
      if (w_word_valid) begin
        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end

      r_core_reset <= (w_next != ST_DONE);
      r_done       <= (w_next == ST_DONE);
      r_error      <= (w_next == ST_ERROR);
    end
  end

  assign s_in.in_ready = w_ready;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_core_reset  = r_core_reset;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader sitting directly upstream of the single-cycle RV32 core. It accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, drives the instruction-memory write port, and holds the core in reset until the whole program is committed. Afterwards it releases the core and goes quiet until the next reset.

## Interface
- WIDTH, 32, instruction word width (fixed at 32; other values unsupported)
- DEPTH, 512, instruction memory depth in words
- ADDR_W, 9, word-address width, $clog2(DEPTH)

- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  WIDTH  word to write
- core_reset  out  1  reset to the core; high until load completes
- done  out  1  program fully loaded, core released
- error  out  1  invalid length header; sticky until reset

## Operation
- Byte accepted when in_valid & in_ready in the same cycle; otherwise in_data ignored.
- Stream format: 2-byte little-endian word count N (LEN_LO then LEN_HI), then 4N bytes, each word's byte 0 first (bits 7:0).
- States: LEN_LO, LEN_HI, LOAD, COMMIT, DONE, ERROR.
- LEN_LO: accept byte -> len[7:0], go LEN_HI.
- LEN_HI: accept byte -> len[15:8]; if N==0 or N>DEPTH go ERROR, else LOAD with word_cnt=0, byte_cnt=0.
- LOAD: each accepted byte goes into the shift register at lane byte_cnt; byte_cnt increments mod 4. On the 4th byte, the packed word is registered onto mem_wdata, mem_addr=word_cnt, mem_we=1 for the next cycle, and word_cnt increments. If that was word N-1, go COMMIT; else stay in LOAD.
- COMMIT: mem_we high for the last word (the registered strobe); in_ready=0; go DONE next cycle.
- DONE: core_reset=0, done=1, in_ready=0; stay until reset.
- ERROR: error=1, core_reset=1, in_ready=0; stay until reset.
- in_ready = 1 in LEN_LO, LEN_HI and LOAD only, and forced 0 while reset is high.
- Counters: byte_cnt 2 bits; word_cnt ADDR_W+1 bits so N=DEPTH needs no wrap. mem_addr = word_cnt[ADDR_W-1:0].
- Length compare uses the full 16-bit N against DEPTH. There is no truncation.

## Timing
- Reset values: state=LEN_LO, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, counters=0.
- Write latency: 4th byte of a word accepted at cycle t -> mem_we=1 with addr/data valid at t+1 only.
- Back-to-back bytes at full rate are supported in LOAD. The next word's first byte may be accepted at t+1 while mem_we is high.
- Last byte accepted at t -> COMMIT at t+1 (mem_we=1) -> DONE at t+2 (core_reset=0, done=1).
- Bubbles on in_valid stall the counters; no timeout.
- Reset mid-operation: returns to LEN_LO next cycle and the partial word is discarded. Memory already written is not cleared. core_reset stays high throughout.
- Reset asserted in DONE: core_reset rises in the next cycle.

## Structure
- Package imem_loader_pkg: state enum (loader_state_t), LEN_BYTES=2, BYTES_PER_WORD=4.
- One sub-module, byte_packer: 4-lane little-endian shift/pack register with lane counter and word_valid pulse. The FSM and address counter stay in imem_loader.
- The core's instruction memory gains a write port driven by mem_we/mem_addr/mem_wdata. The core's reset is reset | core_reset.

## Test plan
- N=1, bytes 01 00 13 05 A0 00 at full rate -> single mem_we, addr 0, wdata 0x00A00513. core_reset low and done high 2 cycles after last byte.
- N=3, 12 payload bytes with random in_valid gaps -> mem_we exactly 3 times, addrs 0,1,2, correct words. No writes during gaps.
- Header 00 00 (N=0) -> error=1 one cycle after second byte. in_ready=0, core_reset stays 1, no mem_we.
- Header 01 02 (N=513 > DEPTH) -> error. Header 00 02 (N=512) -> loads 512 words, last addr 0x1FF, done=1.
- Reset after 5 payload bytes of N=2 -> state LEN_LO, in_ready=1. A fresh stream N=1 writes addr 0 correctly; stale partial bytes don't appear.
- After done, drive in_valid=1 with bytes -> in_ready=0, no mem_we, done/core_reset unchanged.
